// File: rtl/p2s_pkg.sv
// Shared definitions for the multi-lane parallel-to-serial block.
// The width constants describe the default configuration.
package p2s_pkg;

  localparam int ROW_NUM_DEF    = 8;
  localparam int WORD_W_DEF     = 13;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DIV_DEF        = 16;

  localparam int DIV_W = $clog2(DIV_DEF);
  localparam int PTR_W = $clog2(FIFO_DEPTH_DEF);
  localparam int CNT_W = $clog2(WORD_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } lane_state_t;

endpackage

// File: rtl/p2s_lane.sv
// One serial lane: word FIFO feeding an MSB-first shifter with an optional
// even-parity bit and a sticky overflow flag.
module p2s_lane
  import p2s_pkg::*;
#(
  parameter int WORD_W     = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              par_en,
  input  logic [WORD_W-1:0] word,
  input  logic              push,
  input  logic              ovf_clr,
  output logic              s_data,
  output logic              data_valid,
  output logic              fifo_full,
  output logic              ovf,
  output logic [1:0]        state_dbg
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic [WORD_W-1:0] head;
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              par_lat;
  logic              par_bit;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              load;
  logic              shift;
  logic              send_par;
  logic              go_idle;
  lane_state_t       state;
  lane_state_t       state_nxt;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign wr_en     = push && !full;
  assign head      = mem[rd_ptr];
  assign fifo_full = full;
  assign state_dbg = state;

  // Every transition happens on a tick; end of frame reloads back-to-back when possible.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    send_par  = 1'b0;
    go_idle   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            load      = 1'b1;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt != '0) begin
            shift = 1'b1;
          end else if (par_lat) begin
            send_par  = 1'b1;
            state_nxt = PAR;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
          end
        end
        PAR: begin
          if (!empty) begin
            load      = 1'b1;
            state_nxt = SHIFT;
          end else begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          go_idle   = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (load)  rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, load})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A push that finds the FIFO full is dropped even if a pop frees a slot this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ovf <= 1'b0;
    else if (push && full)  ovf <= 1'b1;
    else if (ovf_clr)       ovf <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      par_lat    <= 1'b0;
      par_bit    <= 1'b0;
      s_data     <= 1'b0;
      data_valid <= 1'b0;
    end else if (load) begin
      shreg      <= head;
      bit_cnt    <= LAST_BIT;
      par_lat    <= par_en;
      par_bit    <= ^head;
      s_data     <= head[WORD_W-1];
      data_valid <= 1'b1;
    end else if (shift) begin
      shreg   <= {shreg[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt - CW'(1);
      s_data  <= shreg[WORD_W-2];
    end else if (send_par) begin
      s_data <= par_bit;
    end else if (go_idle) begin
      s_data     <= 1'b0;
      data_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/p2s_lane_array.sv
// ROW_NUM independent serial lanes sharing one bit-rate tick derived from clk_50M.
// lane_state exposes each lane FSM (2 bits per lane) for observation.
module p2s_lane_array #(
  parameter int ROW_NUM    = 8,
  parameter int WORD_W     = 13,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 16
) (
  input  logic                      clk_50M,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      par_en,
  input  logic [ROW_NUM*WORD_W-1:0] p_data,
  input  logic [ROW_NUM-1:0]        p_valid,
  input  logic                      ovf_clr,
  output logic [ROW_NUM-1:0]        s_data,
  output logic [ROW_NUM-1:0]        data_valid,
  output logic [ROW_NUM-1:0]        fifo_full,
  output logic [ROW_NUM-1:0]        ovf,
  output logic                      bit_tick,
  output logic [2*ROW_NUM-1:0]      lane_state
);

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt;

  // Dropping en restarts the bit period from zero so lanes freeze cleanly.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst)                      div_cnt <= '0;
    else if (!en)                 div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                          div_cnt <= div_cnt + DW'(1);
  end

  assign bit_tick = en && (div_cnt == DIV_LAST);

  for (genvar i = 0; i < ROW_NUM; i++) begin : g_lane
    p2s_lane #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_lane (
      .clk        (clk_50M),
      .rst        (rst),
      .tick       (bit_tick),
      .par_en     (par_en),
      .word       (p_data[i*WORD_W +: WORD_W]),
      .push       (p_valid[i]),
      .ovf_clr    (ovf_clr),
      .s_data     (s_data[i]),
      .data_valid (data_valid[i]),
      .fifo_full  (fifo_full[i]),
      .ovf        (ovf[i]),
      .state_dbg  (lane_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_p2s_lane_array.sv
// Self-checking bench for p2s_lane_array: expected serial bits are queued when
// words are pushed and compared as the monitored lane emits them.
module tb_p2s_lane_array;

  localparam int ROW_NUM = 8;
  localparam int WORD_W  = 13;
  localparam int DIV     = 16;

  // clock / reset
  logic                      clk_50M = 1'b0;
  logic                      rst;
  logic                      en;
  logic                      par_en;
  logic [ROW_NUM*WORD_W-1:0] p_data;
  logic [ROW_NUM-1:0]        p_valid;
  logic                      ovf_clr;
  logic [ROW_NUM-1:0]        s_data;
  logic [ROW_NUM-1:0]        data_valid;
  logic [ROW_NUM-1:0]        fifo_full;
  logic [ROW_NUM-1:0]        ovf;
  logic                      bit_tick;
  logic [2*ROW_NUM-1:0]      lane_state;

  always #5 clk_50M = ~clk_50M;

  p2s_lane_array #(
    .ROW_NUM(ROW_NUM), .WORD_W(WORD_W), .FIFO_DEPTH(4), .DIV(DIV)
  ) dut (
    .clk_50M    (clk_50M),
    .rst        (rst),
    .en         (en),
    .par_en     (par_en),
    .p_data     (p_data),
    .p_valid    (p_valid),
    .ovf_clr    (ovf_clr),
    .s_data     (s_data),
    .data_valid (data_valid),
    .fifo_full  (fifo_full),
    .ovf        (ovf),
    .bit_tick   (bit_tick),
    .lane_state (lane_state)
  );

  // scoreboard
  int         n_cmp = 0;
  int         n_err = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_bit;
  int         mon_lane = 0;
  bit         mon_on = 1'b0;
  logic       prev_tick = 1'b0;

  // Outputs move on the edge that ends a tick cycle; check them at the following negedge.
  always @(negedge clk_50M) begin
    if (mon_on && prev_tick && data_valid[mon_lane]) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL serial_bit lane %0d: got bit %0b, expected no bit (queue empty)",
                 mon_lane, s_data[mon_lane]);
      end else begin
        exp_bit = exp_q.pop_front();
        if (s_data[mon_lane] !== exp_bit[0]) begin
          n_err++;
          $display("FAIL serial_bit lane %0d: got %0b, expected %0b (t=%0t)",
                   mon_lane, s_data[mon_lane], exp_bit[0], $time);
        end
      end
    end
    prev_tick = bit_tick;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk_50M);
    #2;
  endtask

  task automatic push_word(input int lane, input logic [WORD_W-1:0] w);
    p_data[lane*WORD_W +: WORD_W] = w;
    p_valid[lane] = 1'b1;
    cyc();
    p_valid = '0;
  endtask

  task automatic expect_word(input logic [WORD_W-1:0] w, input bit with_par);
    for (int b = WORD_W - 1; b >= 0; b--) exp_q.push_back(w[b]);
    if (with_par) exp_q.push_back(^w);
  endtask

  task automatic wait_rise(input int lane, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (data_valid[lane]) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic count_high(input int lane, output int len);
    len = 0;
    while (data_valid[lane] && len < 3000) begin
      len++;
      cyc();
    end
  endtask

  task automatic count_to_tick(output int n);
    n = 1;
    while (!bit_tick && n < 100) begin
      cyc();
      n++;
    end
  endtask

  // tests
  task automatic test_reset();
    int n;
    rst = 1'b1; en = 1'b0; par_en = 1'b0; p_data = '0; p_valid = '0; ovf_clr = 1'b0;
    repeat (3) cyc();
    n_cmp++; if (s_data !== '0)     begin n_err++; $display("FAIL reset_s_data: got %h, expected 0", s_data); end
    n_cmp++; if (data_valid !== '0) begin n_err++; $display("FAIL reset_data_valid: got %h, expected 0", data_valid); end
    n_cmp++; if (fifo_full !== '0)  begin n_err++; $display("FAIL reset_fifo_full: got %h, expected 0", fifo_full); end
    n_cmp++; if (ovf !== '0)        begin n_err++; $display("FAIL reset_ovf: got %h, expected 0", ovf); end
    n_cmp++; if (bit_tick !== 1'b0) begin n_err++; $display("FAIL reset_bit_tick: got %b, expected 0", bit_tick); end
    n_cmp++; if (lane_state !== '0) begin n_err++; $display("FAIL reset_lane_state: got %h, expected 0", lane_state); end
    en = 1'b1;
    cyc();
    rst = 1'b0;
    count_to_tick(n);
    n_cmp++; if (n !== DIV) begin n_err++; $display("FAIL first_tick_delay: got %0d cycles, expected %0d", n, DIV); end
  endtask

  task automatic test_single();
    bit ok; int len;
    mon_lane = 2; mon_on = 1'b1; par_en = 1'b0;
    expect_word(13'h1A5A, 1'b0);
    push_word(2, 13'h1A5A);
    wait_rise(2, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_start: data_valid[2] got %b, expected 1", ok); end
    count_high(2, len);
    n_cmp++; if (len !== WORD_W*DIV) begin n_err++; $display("FAIL single_len: got %0d cycles, expected %0d", len, WORD_W*DIV); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_bits_left: got %0d, expected 0", exp_q.size()); end
    n_cmp++; if (lane_state[5:4] !== 2'd0) begin n_err++; $display("FAIL single_idle: got %0d, expected 0", lane_state[5:4]); end
    mon_on = 1'b0;
  endtask

  task automatic test_parity();
    bit ok; int len;
    mon_lane = 3; mon_on = 1'b1; par_en = 1'b1;
    expect_word(13'h0007, 1'b1);
    push_word(3, 13'h0007);
    wait_rise(3, ok);
    par_en = 1'b0;  // must not affect the frame already started
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL parity_start: data_valid[3] got %b, expected 1", ok); end
    count_high(3, len);
    n_cmp++; if (len !== (WORD_W+1)*DIV) begin n_err++; $display("FAIL parity_len: got %0d cycles, expected %0d", len, (WORD_W+1)*DIV); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL parity_bits_left: got %0d, expected 0", exp_q.size()); end
    mon_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok; int len; logic [WORD_W-1:0] w;
    en = 1'b0; par_en = 1'b0;
    cyc();
    mon_lane = 5; mon_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w = WORD_W'($urandom_range(0, 8191));
      expect_word(w, 1'b0);
      push_word(5, w);
    end
    en = 1'b1;
    wait_rise(5, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_start: data_valid[5] got %b, expected 1", ok); end
    count_high(5, len);
    n_cmp++; if (len !== 3*WORD_W*DIV) begin n_err++; $display("FAIL b2b_len: got %0d cycles, expected %0d", len, 3*WORD_W*DIV); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL b2b_bits_left: got %0d, expected 0", exp_q.size()); end
    n_cmp++; if (lane_state[11:10] !== 2'd0) begin n_err++; $display("FAIL b2b_idle: got %0d, expected 0", lane_state[11:10]); end
    mon_on = 1'b0;
  endtask

  task automatic test_overflow();
    bit ok; int len; int model_cnt; logic [WORD_W-1:0] w;
    en = 1'b0; par_en = 1'b0; model_cnt = 0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      w = WORD_W'($urandom_range(0, 8191));
      if (model_cnt < 4) begin
        expect_word(w, 1'b0);
        model_cnt++;
      end
      push_word(1, w);
      if (i == 2) begin
        n_cmp++; if (fifo_full[1] !== 1'b0) begin n_err++; $display("FAIL ovf_full_after3: got %b, expected 0", fifo_full[1]); end
      end
      if (i == 3) begin
        n_cmp++; if (fifo_full[1] !== 1'b1) begin n_err++; $display("FAIL ovf_full_after4: got %b, expected 1", fifo_full[1]); end
        n_cmp++; if (ovf[1] !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b, expected 0", ovf[1]); end
      end
    end
    n_cmp++; if (ovf[1] !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b, expected 1", ovf[1]); end
    n_cmp++; if (ovf[0] !== 1'b0) begin n_err++; $display("FAIL ovf_other_lane: got %b, expected 0", ovf[0]); end
    ovf_clr = 1'b1;
    push_word(1, 13'h1FFF);
    ovf_clr = 1'b0;
    n_cmp++; if (ovf[1] !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b, expected 1", ovf[1]); end
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf[1] !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b, expected 0", ovf[1]); end
    mon_lane = 1; mon_on = 1'b1; en = 1'b1;
    wait_rise(1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ovf_drain_start: data_valid[1] got %b, expected 1", ok); end
    count_high(1, len);
    n_cmp++; if (len !== 4*WORD_W*DIV) begin n_err++; $display("FAIL ovf_drain_len: got %0d cycles, expected %0d", len, 4*WORD_W*DIV); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL ovf_bits_left: got %0d, expected 0", exp_q.size()); end
    n_cmp++; if (fifo_full[1] !== 1'b0) begin n_err++; $display("FAIL ovf_drained_full: got %b, expected 0", fifo_full[1]); end
    mon_on = 1'b0;
  endtask

  task automatic test_en_gating();
    bit ok; bit held; int len; logic hs; logic hv; logic [WORD_W-1:0] w;
    en = 1'b1; par_en = 1'b0;
    mon_lane = 0; mon_on = 1'b1;
    w = WORD_W'($urandom_range(0, 8191));
    expect_word(w, 1'b0);
    push_word(0, w);
    wait_rise(0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL gate_start: data_valid[0] got %b, expected 1", ok); end
    repeat (5*DIV + 7) cyc();
    en = 1'b0;
    hs = s_data[0]; hv = data_valid[0]; held = 1'b1;
    repeat (100) begin
      cyc();
      if (s_data[0] !== hs || data_valid[0] !== hv || bit_tick !== 1'b0) held = 1'b0;
    end
    n_cmp++; if (held !== 1'b1) begin n_err++; $display("FAIL gate_hold: got held=%b, expected 1", held); end
    n_cmp++; if (hv !== 1'b1) begin n_err++; $display("FAIL gate_mid_frame: data_valid got %b, expected 1", hv); end
    en = 1'b1;
    count_high(0, len);
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL gate_bits_left: got %0d, expected 0", exp_q.size()); end
    mon_on = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    bit ok; bit stayed; int n;
    en = 1'b1; par_en = 1'b0;
    push_word(0, 13'h0F0F);
    push_word(0, 13'h1234);
    wait_rise(0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rmf_start: data_valid[0] got %b, expected 1", ok); end
    repeat (40) cyc();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (s_data !== '0)     begin n_err++; $display("FAIL rmf_s_data: got %h, expected 0", s_data); end
    n_cmp++; if (data_valid !== '0) begin n_err++; $display("FAIL rmf_data_valid: got %h, expected 0", data_valid); end
    n_cmp++; if (bit_tick !== 1'b0) begin n_err++; $display("FAIL rmf_bit_tick: got %b, expected 0", bit_tick); end
    n_cmp++; if (lane_state !== '0) begin n_err++; $display("FAIL rmf_lane_state: got %h, expected 0", lane_state); end
    repeat (3) @(posedge clk_50M);
    #2 rst = 1'b0;
    count_to_tick(n);
    n_cmp++; if (n !== DIV) begin n_err++; $display("FAIL rmf_first_tick: got %0d cycles, expected %0d", n, DIV); end
    stayed = 1'b1;
    repeat (2*DIV) begin
      cyc();
      if (data_valid[0] !== 1'b0) stayed = 1'b0;
    end
    n_cmp++; if (stayed !== 1'b1) begin n_err++; $display("FAIL rmf_fifo_flushed: got stayed=%b, expected 1", stayed); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_en_gating();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
